// File: rtl/vga_sync_if.sv
// Sync bundle between a VGA sync source and the position-recovering decoder.
// The master drives the sync pulses; the slave returns the recovered beam position and lock status.
interface vga_sync_if;
    logic       hsync;
    logic       vsync;
    logic [9:0] hpos;
    logic [9:0] vpos;
    logic       visible;
    logic       frame_start;
    logic       locked;

    modport master (
        output hsync,
        output vsync,
        input  hpos,
        input  vpos,
        input  visible,
        input  frame_start,
        input  locked
    );

    modport slave (
        input  hsync,
        input  vsync,
        output hpos,
        output vpos,
        output visible,
        output frame_start,
        output locked
    );
endinterface

// File: rtl/vga_sync_decoder.sv
// Recovers beam position from incoming HSync/VSync and locks when the line/frame
// timing matches the expected VGA geometry. Fixed two-clock latency from sync input to position.
module vga_sync_decoder #(
    parameter int unsigned HTotal        = 800,
    parameter int unsigned HVisible      = 640,
    parameter int unsigned HSyncStart    = 656,
    parameter int unsigned VTotal        = 525,
    parameter int unsigned VVisible      = 480,
    parameter int unsigned VSyncStart    = 490,
    parameter bit          SyncActiveLow = 1'b1,
    parameter int unsigned LockLines     = 4
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    vga_sync_if.slave vga_io
);
    localparam int unsigned TimeoutClks = 2 * HTotal;
    localparam int unsigned ToW         = $clog2(TimeoutClks);
    localparam int unsigned GoodW       = $clog2(LockLines + 1);

    localparam logic [9:0]       HLast    = 10'(HTotal - 1);
    localparam logic [9:0]       HVis     = 10'(HVisible);
    localparam logic [9:0]       HSyncPos = 10'(HSyncStart);
    localparam logic [9:0]       VLast    = 10'(VTotal - 1);
    localparam logic [9:0]       VVis     = 10'(VVisible);
    localparam logic [9:0]       VSyncPos = 10'(VSyncStart);
    localparam logic [ToW-1:0]   ToLast   = ToW'(TimeoutClks - 1);
    localparam logic [GoodW-1:0] GoodLock = GoodW'(LockLines);

    typedef enum logic [1:0] {StSearch, StHMeasure, StHLocked, StLocked} state_e;

    state_e           state_q, state_d;
    logic [GoodW-1:0] good_q, good_d, good_inc;
    logic [ToW-1:0]   to_q, to_d;
    logic             hs_q, hs_prev_q, vs_q, vs_prev_q;
    logic [9:0]       hpos_q, hpos_d, vpos_q, vpos_d, hinc, vstep;
    logic             locked_q, locked_d, visible_q, visible_d, fs_q, fs_d;
    logic             hs_edge, vs_edge, h_good, v_good, h_bad, v_bad, h_wrap, timeout;

    // Syncs are stored as "asserted" regardless of the line polarity.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hs_q      <= 1'b0;
            hs_prev_q <= 1'b0;
            vs_q      <= 1'b0;
            vs_prev_q <= 1'b0;
        end else begin
            hs_q      <= vga_io.hsync ^ SyncActiveLow;
            hs_prev_q <= hs_q;
            vs_q      <= vga_io.vsync ^ SyncActiveLow;
            vs_prev_q <= vs_q;
        end
    end

    assign hs_edge = hs_q & ~hs_prev_q;
    assign vs_edge = vs_q & ~vs_prev_q;

    // Free-running position the counters would reach without any sync load.
    assign h_wrap = (hpos_q == HLast);
    assign hinc   = h_wrap ? '0 : hpos_q + 10'd1;
    assign vstep  = h_wrap ? ((vpos_q == VLast) ? '0 : vpos_q + 10'd1) : vpos_q;

    assign h_good = (hinc == HSyncPos);
    assign v_good = (vstep == VSyncPos);
    assign h_bad  = hs_edge & ~h_good;
    assign v_bad  = vs_edge & ~v_good;

    assign hpos_d = hs_edge ? HSyncPos : hinc;
    assign vpos_d = vs_edge ? VSyncPos : vstep;

    assign timeout  = ~hs_edge & (to_q == ToLast);
    assign to_d     = hs_edge ? '0 : ((to_q == ToLast) ? to_q : to_q + ToW'(1));
    assign good_inc = good_q + GoodW'(1);

    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        unique case (state_q)
            StSearch: begin
                if (hs_edge) state_d = StHMeasure;
            end
            StHMeasure: begin
                if (hs_edge) begin
                    if (h_good) begin
                        good_d = good_inc;
                        if (good_inc == GoodLock) state_d = StHLocked;
                    end else begin
                        good_d = '0;
                    end
                end
            end
            StHLocked: begin
                if (h_bad) state_d = StSearch;
                else if (vs_edge) state_d = StLocked;
            end
            StLocked: begin
                if (h_bad || v_bad) state_d = StSearch;
            end
            default: state_d = StSearch;
        endcase
        if (timeout) state_d = StSearch;
        if (state_d == StSearch) good_d = '0;
    end

    // Status is registered alongside the position so both describe the same beam point.
    assign locked_d  = (state_d == StLocked);
    assign visible_d = locked_d & (hpos_d < HVis) & (vpos_d < VVis);
    assign fs_d      = locked_d & (hpos_d == '0) & (vpos_d == '0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StSearch;
            good_q    <= '0;
            to_q      <= '0;
            hpos_q    <= '0;
            vpos_q    <= '0;
            locked_q  <= 1'b0;
            visible_q <= 1'b0;
            fs_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            good_q    <= good_d;
            to_q      <= to_d;
            hpos_q    <= hpos_d;
            vpos_q    <= vpos_d;
            locked_q  <= locked_d;
            visible_q <= visible_d;
            fs_q      <= fs_d;
        end
    end

    assign vga_io.hpos        = hpos_q;
    assign vga_io.vpos        = vpos_q;
    assign vga_io.locked      = locked_q;
    assign vga_io.visible     = visible_q;
    assign vga_io.frame_start = fs_q;
endmodule
